// File: rtl/mac_feeder_pkg.sv
// Shared constants and FSM encoding for the MAC feeder sequencer.
package mac_feeder_pkg;

  localparam int DATA_BIT = 16;
  localparam int ADDR_W   = 10;
  localparam int OUT_W    = 2 * DATA_BIT + 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_LOAD_W  = 3'd2,
    ST_LOAD_IF = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/mac_feeder_addr_gen.sv
// Read-side helper: walks the weight and feature address ranges and
// tags each read so the returning data lands on the right MAC strobe.
module mac_feeder_addr_gen
  import mac_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_w,
  input  logic              rd_if,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [ADDR_W-1:0] len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              last_rd,
  output logic              tag_valid,
  output logic              tag_is_w
);

  logic [ADDR_W-1:0] rd_cnt;

  // Address is base plus offset, wrapping naturally at the address width.
  always_comb begin
    mem_rd_en = rd_w | rd_if;
    mem_addr  = '0;
    last_rd   = 1'b0;
    if (rd_w) begin
      mem_addr = w_base + rd_cnt;
      last_rd  = (rd_cnt == ADDR_W'(2));
    end else if (rd_if) begin
      mem_addr = if_base + rd_cnt;
      last_rd  = (rd_cnt == len - ADDR_W'(1));
    end
  end

  // Offset counter restarts at zero at the end of each read phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (mem_rd_en && !last_rd) begin
      rd_cnt <= rd_cnt + ADDR_W'(1);
    end else begin
      rd_cnt <= '0;
    end
  end

  // One-cycle tag matching the memory latency: marks whether next
  // cycle's read data is a weight or a feature.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_is_w  <= 1'b0;
    end else begin
      tag_valid <= mem_rd_en;
      tag_is_w  <= rd_w;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Sequencer feeding weights and features from SRAM into the 3-tap MAC
// and forwarding each full-window MAC sum as an indexed result.
module mac_feeder
  import mac_feeder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   len,
  input  logic [ADDR_W-1:0]   w_base,
  input  logic [ADDR_W-1:0]   if_base,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_BIT-1:0] mem_rdata,
  output logic                mac_clear,
  output logic                mac_w_w,
  output logic [DATA_BIT-1:0] mac_w_in,
  output logic                mac_if_w,
  output logic [DATA_BIT-1:0] mac_if_in,
  input  logic [OUT_W-1:0]    mac_out,
  output logic                res_valid,
  output logic [OUT_W-1:0]    res_data,
  output logic [ADDR_W-1:0]   res_idx
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              rd_w;
  logic              rd_if;
  logic              last_rd;
  logic              tag_valid;
  logic              tag_is_w;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] w_base_q;
  logic [ADDR_W-1:0] if_base_q;
  logic [ADDR_W-1:0] if_cnt;

  assign accept = (state == ST_IDLE) && start;
  assign rd_w   = (state == ST_LOAD_W);
  assign rd_if  = (state == ST_LOAD_IF);

  mac_feeder_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .rd_w      (rd_w),
    .rd_if     (rd_if),
    .w_base    (w_base_q),
    .if_base   (if_base_q),
    .len       (len_q),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .last_rd   (last_rd),
    .tag_valid (tag_valid),
    .tag_is_w  (tag_is_w)
  );

  // Job parameters are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      w_base_q  <= '0;
      if_base_q <= '0;
    end else if (accept) begin
      len_q     <= len;
      w_base_q  <= w_base;
      if_base_q <= if_base;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and control outputs; too-short jobs skip straight to DONE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mac_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len < ADDR_W'(3)) ? ST_DONE : ST_CLR;
      end
      ST_CLR: begin
        busy      = 1'b1;
        mac_clear = 1'b1;
        state_nxt = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        busy = 1'b1;
        if (last_rd) state_nxt = ST_LOAD_IF;
      end
      ST_LOAD_IF: begin
        busy = 1'b1;
        if (last_rd) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!tag_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes follow the tagged read data; data buses are quiet when idle.
  always_comb begin
    mac_w_w   = tag_valid && tag_is_w;
    mac_if_w  = tag_valid && !tag_is_w;
    mac_w_in  = mac_w_w  ? mem_rdata : '0;
    mac_if_in = mac_if_w ? mem_rdata : '0;
    res_data  = res_valid ? mac_out : '0;
  end

  // Counts feature writes; from the third one on, the MAC window is full
  // and next cycle's mac_out is a result for index (count - 2).
  always_ff @(posedge clk) begin
    if (rst || state == ST_CLR) begin
      if_cnt    <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
    end else begin
      res_valid <= mac_if_w && (if_cnt >= ADDR_W'(2));
      res_idx   <= (mac_if_w && (if_cnt >= ADDR_W'(2))) ? if_cnt - ADDR_W'(2) : '0;
      if (mac_if_w) if_cnt <= if_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: behavioural SRAM and MAC around the DUT, a
// correlation reference model feeding a scoreboard, and a monitor.
module tb_mac_feeder;
  import mac_feeder_pkg::*;

  localparam int MEM_N = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_W-1:0]   len;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   if_base;
  logic                busy;
  logic                done;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_BIT-1:0] mem_rdata;
  logic                mac_clear;
  logic                mac_w_w;
  logic [DATA_BIT-1:0] mac_w_in;
  logic                mac_if_w;
  logic [DATA_BIT-1:0] mac_if_in;
  logic [OUT_W-1:0]    mac_out;
  logic                res_valid;
  logic [OUT_W-1:0]    res_data;
  logic [ADDR_W-1:0]   res_idx;

  mac_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .w_base    (w_base),
    .if_base   (if_base),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mac_clear (mac_clear),
    .mac_w_w   (mac_w_w),
    .mac_w_in  (mac_w_in),
    .mac_if_w  (mac_if_w),
    .mac_if_in (mac_if_in),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (res_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle number; cycle N runs from the Nth rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DATA_BIT-1:0] mem [0:MEM_N-1];
  // Single-port SRAM with one cycle of read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  logic signed [DATA_BIT-1:0] mw [3];
  logic signed [DATA_BIT-1:0] mx [3];
  // 3-tap MAC: shift registers for weights and features, cleared by rst or clear.
  always @(posedge clk) begin
    if (rst || mac_clear) begin
      for (int i = 0; i < 3; i++) begin
        mw[i] <= '0;
        mx[i] <= '0;
      end
    end else begin
      if (mac_w_w) begin
        mw[0] <= mac_w_in;
        mw[1] <= mw[0];
        mw[2] <= mw[1];
      end
      if (mac_if_w) begin
        mx[0] <= mac_if_in;
        mx[1] <= mx[0];
        mx[2] <= mx[1];
      end
    end
  end

  function automatic logic signed [OUT_W-1:0] wideMul(logic signed [DATA_BIT-1:0] a,
                                                      logic signed [DATA_BIT-1:0] b);
    logic signed [OUT_W-1:0] aw;
    logic signed [OUT_W-1:0] bw;
    aw = a;
    bw = b;
    return aw * bw;
  endfunction

  assign mac_out = wideMul(mw[0], mx[0]) + wideMul(mw[1], mx[1]) + wideMul(mw[2], mx[2]);

  typedef struct {
    int     idx;
    longint val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  int   rd_cnt = 0, wstb_cnt = 0, ifstb_cnt = 0, clr_cnt = 0;
  int   busy_cnt = 0, done_cnt = 0, res_cnt = 0;
  int   last_done_cyc = 0, last_res_cyc = 0;
  logic prev_rd = 1'b0;

  int   c0, s_rd, s_w, s_if, s_clr, s_busy, s_done, s_res;

  function automatic longint refY(int wb, int ib, int j);
    longint acc = 0;
    for (int k = 0; k < 3; k++)
      acc += longint'(mem[(wb + k) % MEM_N]) * longint'(mem[(ib + j + k) % MEM_N]);
    return acc;
  endfunction

  function automatic logic anyOut();
    return busy | done | mem_rd_en | (|mem_addr) | mac_clear | mac_w_w | (|mac_w_in)
         | mac_if_w | (|mac_if_in) | res_valid | (|res_data) | (|res_idx);
  endfunction

  task automatic checkOutput(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_rd_en) rd_cnt++;
      if (mac_w_w) wstb_cnt++;
      if (mac_if_w) ifstb_cnt++;
      if (mac_clear) clr_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (mac_w_w || mac_if_w) checkOutput("strobe_after_read", prev_rd, 1);
      if (!mac_w_w) checkOutput("w_in_idle_zero", mac_w_in, 0);
      if (!mac_if_w) checkOutput("if_in_idle_zero", mac_if_in, 0);
      if (res_valid) begin
        res_cnt++;
        last_res_cyc = cyc;
        if (sbq.size() == 0) begin
          checkOutput("unexpected_result", res_idx, -1);
        end else begin
          e = sbq.pop_front();
          checkOutput("res_idx", res_idx, e.idx);
          checkOutput("res_data", longint'($signed(res_data)), e.val);
        end
      end else begin
        checkOutput("res_idle_zero", (res_data != '0 || res_idx != '0), 0);
      end
      prev_rd = mem_rd_en;
    end
  endtask

  task automatic snap();
    c0 = cyc;
    s_rd = rd_cnt; s_w = wstb_cnt; s_if = ifstb_cnt; s_clr = clr_cnt;
    s_busy = busy_cnt; s_done = done_cnt; s_res = res_cnt;
  endtask

  task automatic pushExpected(int wb, int ib, int ln);
    exp_t e;
    for (int j = 0; j <= ln - 3; j++) begin
      e.idx = j;
      e.val = refY(wb, ib, j);
      sbq.push_back(e);
    end
  endtask

  task automatic applyStimulus(int wb, int ib, int ln, bit expect_res);
    @(posedge clk);
    #1;
    w_base  = ADDR_W'(wb);
    if_base = ADDR_W'(ib);
    len     = ADDR_W'(ln);
    start   = 1'b1;
    snap();
    if (expect_res) pushExpected(wb, ib, ln);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(int need, int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt - s_done >= need) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done_timeout", done_cnt - s_done, need);
  endtask

  task automatic checkJob(int ln);
    bit full;
    full = (ln >= 3);
    waitDone(1, 100 + 2 * ln);
    repeat (2) @(negedge clk);
    checkOutput("done_cycle", last_done_cyc - c0, full ? 7 + ln : 1);
    checkOutput("busy_cycles", busy_cnt - s_busy, full ? 7 + ln : 1);
    checkOutput("done_pulses", done_cnt - s_done, 1);
    checkOutput("reads", rd_cnt - s_rd, full ? 3 + ln : 0);
    checkOutput("w_strobes", wstb_cnt - s_w, full ? 3 : 0);
    checkOutput("if_strobes", ifstb_cnt - s_if, full ? ln : 0);
    checkOutput("clears", clr_cnt - s_clr, full ? 1 : 0);
    checkOutput("results", res_cnt - s_res, full ? ln - 2 : 0);
    if (full) checkOutput("last_res_cycle", last_res_cyc - c0, 6 + ln);
    checkOutput("scoreboard_empty", sbq.size(), 0);
  endtask

  task automatic loadBasic();
    for (int i = 0; i < 3; i++) mem[100 + i] = DATA_BIT'(i + 1);
    for (int i = 0; i < 5; i++) mem[200 + i] = DATA_BIT'(i + 1);
  endtask

  initial begin
    int ln, wb, ib;
    rst = 1'b1; start = 1'b0; len = '0; w_base = '0; if_base = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = '0;
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs_zero", anyOut(), 0);

    $display("[TB] basic job");
    loadBasic();
    applyStimulus(100, 200, 5, 1);
    checkJob(5);

    $display("[TB] signed extremes");
    for (int i = 0; i < 3; i++) begin
      mem[110 + i] = 16'h8000;
      mem[210 + i] = 16'h8000;
      mem[120 + i] = 16'h7fff;
    end
    applyStimulus(110, 210, 3, 1);
    checkJob(3);
    applyStimulus(120, 210, 3, 1);
    checkJob(3);

    $display("[TB] mixed sign");
    mem[130] = -16'sd1; mem[131] = 16'sd2; mem[132] = -16'sd3;
    mem[230] = 16'sd4; mem[231] = -16'sd5; mem[232] = 16'sd6; mem[233] = 16'sd7;
    applyStimulus(130, 230, 4, 1);
    checkJob(4);

    $display("[TB] short jobs");
    applyStimulus(130, 230, 2, 1);
    checkJob(2);
    applyStimulus(130, 230, 0, 1);
    checkJob(0);

    $display("[TB] reset mid-job then restart");
    for (int i = 0; i < 3; i++) mem[500 + i] = DATA_BIT'(9 - i);
    for (int i = 0; i < 8; i++) mem[600 + i] = DATA_BIT'(1000 + 37 * i);
    applyStimulus(500, 600, 8, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_outputs_zero", anyOut(), 0);
    repeat (15) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - s_done, 0);
    checkOutput("abort_no_results", res_cnt - s_res, 0);
    checkOutput("abort_reads", rd_cnt - s_rd, 6);
    checkOutput("abort_if_strobes", ifstb_cnt - s_if, 2);
    loadBasic();
    applyStimulus(100, 200, 5, 1);
    checkJob(5);

    $display("[TB] held start with address wrap");
    for (int i = 0; i < 4; i++) mem[1020 + i] = DATA_BIT'(3 * i - 5);
    mem[0] = 16'sd11; mem[1] = -16'sd13;
    for (int i = 0; i < 3; i++) mem[300 + i] = DATA_BIT'(7 - 4 * i);
    for (int i = 0; i < 6; i++) mem[400 + i] = DATA_BIT'(100 * i - 250);
    @(posedge clk);
    #1;
    w_base = ADDR_W'(1020); if_base = ADDR_W'(1022); len = ADDR_W'(4); start = 1'b1;
    snap();
    pushExpected(1020, 1022, 4);
    pushExpected(300, 400, 6);
    repeat (2) @(posedge clk);
    #1;
    w_base = ADDR_W'(300); if_base = ADDR_W'(400); len = ADDR_W'(6);
    waitDone(1, 100);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(2, 100);
    repeat (2) @(negedge clk);
    checkOutput("b2b_done_pulses", done_cnt - s_done, 2);
    checkOutput("b2b_second_done_cycle", last_done_cyc - c0, 25);
    checkOutput("b2b_reads", rd_cnt - s_rd, 16);
    checkOutput("b2b_results", res_cnt - s_res, 6);
    checkOutput("b2b_scoreboard_empty", sbq.size(), 0);

    $display("[TB] random jobs");
    for (int r = 0; r < 10; r++) begin
      ln = $urandom_range(0, 14);
      wb = $urandom_range(0, MEM_N - 1);
      ib = $urandom_range(0, MEM_N - 1);
      for (int k = 0; k < 3; k++) mem[(wb + k) % MEM_N] = DATA_BIT'($urandom);
      for (int k = 0; k < ln; k++) mem[(ib + k) % MEM_N] = DATA_BIT'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(wb, ib, ln, 1);
      checkJob(ln);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
